// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream engine.
// Holds the FSM state encoding and the ceiling-log2 helper used to size counters and pointers.
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// In-order circular buffer that absorbs words returning from the FIFO read pipe.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int PW        = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int OW        = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [OW-1:0]         o_occ,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [OW-1:0]         r_occ;
    logic                  w_popOk;
    logic                  w_pushOk;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_empty  = (r_occ == '0);
    assign o_full   = (r_occ == OW'(DEPTH));
    assign o_occ    = r_occ;
    assign o_data   = r_mem[r_rdPtr];
    assign w_popOk  = i_pop & ~o_empty;
    assign w_pushOk = i_push & (~o_full | w_popOk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pushOk) begin
                r_mem[r_wrPtr] <= i_push_data;
                r_wrPtr        <= nextPtr(r_wrPtr);
            end
            if (w_popOk) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The upstream credit check keeps inflight+occ below DEPTH, so this never fires in a correct system.
    a_noPushWhenFull: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine for the async FIFO: issues credit-limited reads, tracks the read latency,
// and presents returned words downstream as a valid/ready stream.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_glb,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int OW = clog2(BUF_DEPTH + 1);
    localparam int SW = OW + 1;

    state_t                r_state;
    logic                  r_busy;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [OW-1:0]         r_inflight;
    logic [CNT_WIDTH-1:0]  r_wordCnt;

    logic [OW-1:0]         w_occ;
    logic                  w_bufFull;
    logic                  w_bufEmpty;
    logic [DATA_WIDTH-1:0] w_bufData;
    logic [SW-1:0]         w_credits;
    logic                  w_issue;
    logic                  w_land;
    logic                  w_pop;
    logic                  w_pending;

    assign w_credits  = {1'b0, r_inflight} + {1'b0, w_occ};
    assign w_issue    = (r_state == S_RUN) & ~fifo_empty & (w_credits < SW'(BUF_DEPTH)) & ~rst_glb;
    assign w_land     = r_pipe[RD_LATENCY-1];
    assign w_pop      = m_valid & m_ready;
    // A read issued this cycle is not yet counted, but must keep the FSM out of IDLE.
    assign w_pending  = (w_credits != '0) | w_issue;

    assign fifo_rd_en = w_issue;
    assign m_valid    = ~w_bufEmpty;
    assign m_data     = w_bufData;
    assign busy       = r_busy;
    assign word_cnt   = r_wordCnt;

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skidBuf (
        .clk         (rd_clk),
        .rst         (rst_glb),
        .i_push      (w_land),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_data      (w_bufData),
        .o_occ       (w_occ),
        .o_full      (w_bufFull),
        .o_empty     (w_bufEmpty)
    );

    always_ff @(posedge rd_clk or posedge rst_glb) begin
        if (rst_glb) begin
            r_pipe     <= '0;
            r_inflight <= '0;
            r_wordCnt  <= '0;
        end else begin
            r_pipe     <= RD_LATENCY'({r_pipe, w_issue});
            r_inflight <= r_inflight + OW'(w_issue) - OW'(w_land);
            if (w_pop) begin
                r_wordCnt <= r_wordCnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rst_glb) begin
        if (rst_glb) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        r_state <= w_pending ? S_DRAIN : S_IDLE;
                        r_busy  <= w_pending;
                    end
                end
                S_DRAIN: begin
                    if (en) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else if (!w_pending) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
